// File: rtl/tx_serial_pkg.sv
// tx_serial_pkg
// Shared definitions for the BCD-to-ASCII serial transmitter:
//   - FSM state encodings (4-bit codes, also shown on the debug display)
//   - ASCII constants used by the character map
//   - frame length helper as a function of the number of stop bits
package tx_serial_pkg;

    localparam logic [3:0] EST_INICIAL     = 4'd0;
    localparam logic [3:0] EST_PREPARACAO  = 4'd1;
    localparam logic [3:0] EST_TRANSMISSAO = 4'd2;
    localparam logic [3:0] EST_PROXIMO     = 4'd3;
    localparam logic [3:0] EST_FINAL       = 4'd4;

    typedef enum logic [3:0] {
        ST_INICIAL     = EST_INICIAL,
        ST_PREPARACAO  = EST_PREPARACAO,
        ST_TRANSMISSAO = EST_TRANSMISSAO,
        ST_PROXIMO     = EST_PROXIMO,
        ST_FINAL       = EST_FINAL
    } estado_t;

    localparam logic [6:0] ASCII_ZERO     = 7'h30;
    localparam logic [6:0] ASCII_INVALIDO = 7'h3F;
    localparam logic [6:0] ASCII_CR       = 7'h0D;
    localparam logic [6:0] ASCII_LF       = 7'h0A;

    // start + 7 data + parity + stop bits
    function automatic int unsigned comprimento_quadro(input int unsigned stop_bits);
        return 32'd9 + stop_bits;
    endfunction

endpackage

// File: rtl/tx_serial_quadro.sv
// tx_serial_quadro
// Sends one asynchronous frame: start(0), 7 data bits LSB-first, parity,
// STOP_BITS stop bits(1). Each bit lasts DIV_TICK clock cycles.
// Ports:
//   clock      in  system clock
//   reset      in  synchronous active-high reset
//   carrega    in  load a new frame (restarts the tick counter)
//   dado[6:0]  in  7-bit character to send
//   fim_quadro out one-cycle pulse in the last cycle of the last stop bit
//   serial     out registered serial bit, idle high
module tx_serial_quadro
    import tx_serial_pkg::*;
#(
    parameter int DIV_TICK  = 434,
    parameter int PARIDADE  = 0,
    parameter int STOP_BITS = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       carrega,
    input  logic [6:0] dado,
    output logic       fim_quadro,
    output logic       serial
);

    localparam int unsigned    L        = comprimento_quadro(STOP_BITS);
    localparam int             TW       = $clog2(DIV_TICK);
    localparam logic [TW-1:0]  TICK_MAX = TW'(DIV_TICK - 1);
    localparam logic [3:0]     BIT_MAX  = 4'(L - 1);

    logic [TW-1:0] r_tick;
    logic [3:0]    r_bit;
    logic [L-2:0]  r_quadro;   // bits still to send after the start bit
    logic          r_ativo;
    logic          r_serial;

    logic w_paridade;
    logic w_fim_bit;

    // Even parity makes the total count of ones even; odd flips it.
    assign w_paridade = (^dado) ^ (PARIDADE != 0);
    assign w_fim_bit  = r_ativo && (r_tick == TICK_MAX);
    assign fim_quadro = w_fim_bit && (r_bit == BIT_MAX);
    assign serial     = r_serial;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ativo  <= 1'b0;
            r_serial <= 1'b1;
            r_tick   <= '0;
            r_bit    <= '0;
        end else if (carrega) begin
            r_ativo  <= 1'b1;
            r_serial <= 1'b0;
            r_tick   <= '0;
            r_bit    <= '0;
        end else if (w_fim_bit) begin
            r_tick   <= '0;
            r_bit    <= r_bit + 4'd1;
            r_serial <= r_quadro[0];
            if (fim_quadro) begin
                r_ativo  <= 1'b0;
                r_serial <= 1'b1;
            end
        end else if (r_ativo) begin
            r_tick <= r_tick + 1'b1;
        end
    end

    // Payload shifter; ones are shifted in so the line stays high afterwards.
    always_ff @(posedge clock) begin
        if (carrega) begin
            r_quadro <= {{STOP_BITS{1'b1}}, w_paridade, dado};
        end else if (w_fim_bit) begin
            r_quadro <= {1'b1, r_quadro[L-2:1]};
        end
    end

endmodule

// File: rtl/tx_bcd_ascii_serial.sv
// tx_bcd_ascii_serial
// Latches NUM_DIGITOS BCD digits on a rising edge of inicio and sends them
// MSD-first as ASCII serial frames, followed by SEPARADOR.
// Build option: define TX_CRLF_EN to append CR and LF after SEPARADOR.
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   inicio                start request (level, edge-detected internally)
//   dados                 BCD digits, MSD in the top nibble
//   saida_serial          registered serial line, idle high
//   pronto                one-cycle pulse at the end of the message
//   ocupado               high from preparacao through final
//   db_inicio, db_saida_serial, db_estado, db_indice  debug copies
module tx_bcd_ascii_serial
    import tx_serial_pkg::*;
#(
    parameter int         NUM_DIGITOS = 3,
    parameter int         DIV_TICK    = 434,
    parameter int         PARIDADE    = 0,
    parameter int         STOP_BITS   = 2,
    parameter logic [6:0] SEPARADOR   = 7'h23
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     inicio,
    input  logic [4*NUM_DIGITOS-1:0] dados,
    output logic                     saida_serial,
    output logic                     pronto,
    output logic                     ocupado,
    output logic                     db_inicio,
    output logic                     db_saida_serial,
    output logic [3:0]               db_estado,
    output logic [3:0]               db_indice
);

`ifdef TX_CRLF_EN
    localparam int NUM_CHARS = NUM_DIGITOS + 3;
`else
    localparam int NUM_CHARS = NUM_DIGITOS + 1;
`endif
    localparam logic [3:0] ULTIMO = 4'(NUM_CHARS - 1);

    estado_t                  r_estado;
    estado_t                  w_proximo;
    logic                     r_inicio_ant;
    logic [4*NUM_DIGITOS-1:0] r_dados;
    logic [3:0]               r_indice;

    logic       w_borda;
    logic       w_carrega;
    logic       w_fim_quadro;
    logic       w_serial;
    logic [3:0] w_digito;
    logic [6:0] w_char;

    function automatic logic [6:0] bcd_para_ascii(input logic [3:0] d);
        return (d <= 4'd9) ? (ASCII_ZERO | {3'b000, d}) : ASCII_INVALIDO;
    endfunction

    assign w_borda = inicio & ~r_inicio_ant;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado <= ST_INICIAL;
        end else begin
            r_estado <= w_proximo;
        end
    end

    always_comb begin
        w_proximo = r_estado;
        w_carrega = 1'b0;
        pronto    = 1'b0;
        ocupado   = 1'b0;
        case (r_estado)
            ST_INICIAL: begin
                if (w_borda) w_proximo = ST_PREPARACAO;
            end
            ST_PREPARACAO: begin
                ocupado   = 1'b1;
                w_carrega = 1'b1;
                w_proximo = ST_TRANSMISSAO;
            end
            ST_TRANSMISSAO: begin
                ocupado = 1'b1;
                if (w_fim_quadro) w_proximo = ST_PROXIMO;
            end
            ST_PROXIMO: begin
                ocupado   = 1'b1;
                w_proximo = (r_indice == ULTIMO) ? ST_FINAL : ST_PREPARACAO;
            end
            ST_FINAL: begin
                ocupado   = 1'b1;
                pronto    = 1'b1;
                w_proximo = ST_INICIAL;
            end
            default: w_proximo = ST_INICIAL;
        endcase
    end

    // Edge detector starts at 1 so a request held through reset is not taken.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_inicio_ant <= 1'b1;
            r_indice     <= '0;
        end else begin
            r_inicio_ant <= inicio;
            if (r_estado == ST_INICIAL && w_borda) begin
                r_indice <= '0;
            end else if (r_estado == ST_PROXIMO && r_indice != ULTIMO) begin
                r_indice <= r_indice + 4'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (r_estado == ST_INICIAL && w_borda) begin
            r_dados <= dados;
        end
    end

    // Index 0 selects the most significant digit.
    always_comb begin
        w_digito = '0;
        for (int k = 0; k < NUM_DIGITOS; k++) begin
            if (r_indice == 4'(k)) w_digito = r_dados[4*(NUM_DIGITOS-1-k) +: 4];
        end
    end

    always_comb begin
        w_char = SEPARADOR;
        if (r_indice < 4'(NUM_DIGITOS)) begin
            w_char = bcd_para_ascii(w_digito);
        end
`ifdef TX_CRLF_EN
        else if (r_indice == 4'(NUM_DIGITOS + 1)) begin
            w_char = ASCII_CR;
        end else if (r_indice == 4'(NUM_DIGITOS + 2)) begin
            w_char = ASCII_LF;
        end
`endif
    end

    tx_serial_quadro #(
        .DIV_TICK  (DIV_TICK),
        .PARIDADE  (PARIDADE),
        .STOP_BITS (STOP_BITS)
    ) u_quadro (
        .clock      (clock),
        .reset      (reset),
        .carrega    (w_carrega),
        .dado       (w_char),
        .fim_quadro (w_fim_quadro),
        .serial     (w_serial)
    );

    assign saida_serial    = w_serial;
    assign db_inicio       = inicio;
    assign db_saida_serial = w_serial;
    assign db_estado       = r_estado;
    assign db_indice       = r_indice;

endmodule

// File: tb/tb_tx_bcd_ascii_serial.sv
// tb_tx_bcd_ascii_serial
// Directed bench for tx_bcd_ascii_serial with DIV_TICK=4, STOP_BITS=2,
// even parity. Frame = 11 bits = 44 cycles; a 4-character message ends
// with pronto at t+185 (t = cycle the inicio edge is sampled).
module tb_tx_bcd_ascii_serial;

`ifdef TX_CRLF_EN
    localparam int TB_N = 1;
`else
    localparam int TB_N = 3;
`endif
    localparam int D        = 4;
    localparam int PAR      = 0;
    localparam int L        = 11;
    localparam int F        = 44;
    localparam int T_PRONTO = 185;

    logic              clock = 1'b0;
    logic              reset;
    logic              inicio;
    logic [4*TB_N-1:0] dados;
    logic              saida_serial, pronto, ocupado, db_inicio, db_saida_serial;
    logic [3:0]        db_estado, db_indice;

    tx_bcd_ascii_serial #(
        .NUM_DIGITOS (TB_N),
        .DIV_TICK    (D),
        .PARIDADE    (PAR),
        .STOP_BITS   (2),
        .SEPARADOR   (7'h23)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .inicio          (inicio),
        .dados           (dados),
        .saida_serial    (saida_serial),
        .pronto          (pronto),
        .ocupado         (ocupado),
        .db_inicio       (db_inicio),
        .db_saida_serial (db_saida_serial),
        .db_estado       (db_estado),
        .db_indice       (db_indice)
    );

    always #5 clock = ~clock;

    int ciclo = 0;
    always @(posedge clock) ciclo <= ciclo + 1;

    int n_pronto     = 0;
    int ciclo_pronto = -1;
    always @(negedge clock) begin
        if (pronto === 1'b1) begin
            n_pronto     <= n_pronto + 1;
            ciclo_pronto <= ciclo;
        end
    end

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [7:0] exp_c [0:3];
    int         t0;
    int         np;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic ir_ate(input int alvo);
        while (ciclo < alvo) @(negedge clock);
    endtask

    // Expected frame, bit 0 = first bit on the line.
    function automatic logic [10:0] quadro(input logic [7:0] c);
        return {2'b11, (^c[6:0]) ^ 1'(PAR), c[6:0], 1'b0};
    endfunction

    // Called at the negedge where inicio has just been raised (ciclo == t0).
    task automatic checa_mensagem(input string tag, input int tb);
        logic [10:0] got;
        int          base;
        int          npa;
        npa = n_pronto;
        ir_ate(tb + 1);
        chk({tag, " ocupado"}, 32'(ocupado), 32'd1);
        chk({tag, " estado prep"}, 32'(db_estado), 32'd1);
        for (int k = 0; k < 4; k++) begin
            base = tb + 2 + k * (F + 2);
            ir_ate(base - 1);
            chk($sformatf("%s idle %0d", tag, k), 32'(saida_serial), 32'd1);
            ir_ate(base);
            chk($sformatf("%s indice %0d", tag, k), 32'(db_indice), 32'(k));
            for (int b = 0; b < L; b++) begin
                ir_ate(base + b * D + D / 2);
                got[b] = saida_serial;
            end
            chk($sformatf("%s quadro %0d", tag, k), 32'(got), 32'(quadro(exp_c[k])));
        end
        ir_ate(tb + T_PRONTO - 1);
        chk({tag, " pronto cedo"}, 32'(pronto), 32'd0);
        ir_ate(tb + T_PRONTO);
        chk({tag, " pronto"}, 32'(pronto), 32'd1);
        chk({tag, " estado final"}, 32'(db_estado), 32'd4);
        ir_ate(tb + T_PRONTO + 1);
        chk({tag, " pronto pulso"}, 32'(pronto), 32'd0);
        chk({tag, " ocupado fim"}, 32'(ocupado), 32'd0);
        chk({tag, " n_pronto"}, 32'(n_pronto), 32'(npa + 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        inicio = 1'b1;
        dados  = '0;
        repeat (3) @(negedge clock);
        chk("rst saida", 32'(saida_serial), 32'd1);
        chk("rst pronto", 32'(pronto), 32'd0);
        chk("rst ocupado", 32'(ocupado), 32'd0);
        chk("rst indice", 32'(db_indice), 32'd0);
        chk("rst estado", 32'(db_estado), 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        chk("inicio alto pos-reset", 32'(ocupado), 32'd0);
        chk("db_inicio", 32'(db_inicio), 32'd1);
        inicio = 1'b0;
        @(negedge clock);

`ifndef TX_CRLF_EN
        // 1: 259 -> "259#"
        dados = 12'h259;
        exp_c = '{8'h32, 8'h35, 8'h39, 8'h23};
        inicio = 1'b1;
        t0 = ciclo;
        checa_mensagem("t1", t0);
        chk("db_saida", 32'(db_saida_serial), 32'(saida_serial));
        inicio = 1'b0;
        @(negedge clock);

        // 2: 0A7 -> "0?7#"
        dados = 12'h0A7;
        exp_c = '{8'h30, 8'h3F, 8'h37, 8'h23};
        inicio = 1'b1;
        t0 = ciclo;
        checa_mensagem("t2", t0);
        inicio = 1'b0;
        @(negedge clock);

        // 3: held high and re-pulsed while busy -> single message
        dados = 12'h111;
        inicio = 1'b1;
        t0 = ciclo;
        np = n_pronto;
        ir_ate(t0 + 40);
        inicio = 1'b0;
        ir_ate(t0 + 45);
        inicio = 1'b1;
        ir_ate(t0 + 300);
        chk("t3 n_pronto", 32'(n_pronto), 32'(np + 1));
        chk("t3 ciclo_pronto", 32'(ciclo_pronto), 32'(t0 + T_PRONTO));
        chk("t3 ocupado", 32'(ocupado), 32'd0);
        inicio = 1'b0;
        @(negedge clock);
        dados = 12'h259;
        exp_c = '{8'h32, 8'h35, 8'h39, 8'h23};
        inicio = 1'b1;
        t0 = ciclo;
        checa_mensagem("t3b", t0);
        inicio = 1'b0;
        @(negedge clock);

        // 4: reset in the middle of a frame
        dados = 12'h000;
        inicio = 1'b1;
        t0 = ciclo;
        np = n_pronto;
        ir_ate(t0 + 60);
        chk("t4 saida antes", 32'(saida_serial), 32'd0);
        reset = 1'b1;
        ir_ate(t0 + 61);
        chk("t4 saida", 32'(saida_serial), 32'd1);
        chk("t4 ocupado", 32'(ocupado), 32'd0);
        chk("t4 estado", 32'(db_estado), 32'd0);
        ir_ate(t0 + 63);
        reset = 1'b0;
        ir_ate(t0 + 300);
        chk("t4 sem pronto", 32'(n_pronto), 32'(np));
        chk("t4 sem inicio", 32'(ocupado), 32'd0);
        inicio = 1'b0;
        @(negedge clock);

        // 5: dados changes after the start are ignored
        dados = 12'h259;
        exp_c = '{8'h32, 8'h35, 8'h39, 8'h23};
        inicio = 1'b1;
        t0 = ciclo;
        fork
            begin
                ir_ate(t0 + 10);
                dados = 12'h999;
            end
        join_none
        checa_mensagem("t5", t0);
        inicio = 1'b0;
        @(negedge clock);
`else
        // 6: single digit with CR/LF -> "5#\r\n"
        dados = 4'h5;
        exp_c = '{8'h35, 8'h23, 8'h0D, 8'h0A};
        inicio = 1'b1;
        t0 = ciclo;
        checa_mensagem("t6", t0);
        inicio = 1'b0;
        @(negedge clock);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
